// File: rtl/lsc_uart_pkg.sv
// Shared definitions for the UART text emitters: ASCII control bytes,
// the hex-frame FSM state encoding and a nibble-to-ASCII helper.
package lsc_uart_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_STAR = 8'h2A;

  // Each state other than IDLE/WAIT names the byte on o_dout during that cycle.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WAIT  = 4'd1,
    ST_DIGIT = 4'd2,
    ST_SEP   = 4'd3,
    ST_STAR  = 4'd4,
    ST_CK_HI = 4'd5,
    ST_CK_LO = 4'd6,
    ST_CR    = 4'd7,
    ST_LF    = 4'd8
  } hex_tx_state_t;

  // Uppercase hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    if (nib < 4'd10) begin
      return 8'h30 + wide;
    end
    return 8'h37 + wide;
  endfunction

endpackage

// File: rtl/lsc_uart_hex_tx.sv
// Serialises a latched vector of words into one ASCII hex text frame for the
// SPRAM UART buffer. Optional "*XX" checksum trailer: LSC_UART_HEX_CHKSUM_EN.
module lsc_uart_hex_tx
  import lsc_uart_pkg::*;
#(
  parameter int         NWORD      = 4,
  parameter int         WBITS      = 16,
  parameter logic [7:0] SEP        = 8'h2C,
  parameter bit         WAIT_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [NWORD*WBITS-1:0] i_data,
  input  logic                   i_empty,
  output logic [7:0]             o_dout,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam int NNIB = WBITS / 4;
  localparam int NCW  = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam int WCW  = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [NCW-1:0] NIB_LAST  = NCW'(NNIB - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORD - 1);

  hex_tx_state_t          state;
  logic [NWORD*WBITS-1:0] shadow;
  logic [WCW-1:0]         word_cnt;
  logic [NCW-1:0]         nib_cnt;

  // Counters always describe the byte currently on o_dout; sel_* point at the
  // digit that the next transition will load.
  logic [WCW-1:0]   sel_word;
  logic [NCW-1:0]   sel_nib;
  logic [WBITS-1:0] cur_word;
  logic [7:0]       digit;

`ifdef LSC_UART_HEX_CHKSUM_EN
  logic [7:0] acc;
`endif

  always_comb begin
    sel_word = '0;
    sel_nib  = '0;
    case (state)
      ST_DIGIT: begin
        sel_word = word_cnt;
        if (nib_cnt != NIB_LAST) begin
          sel_nib = nib_cnt + 1'b1;
        end
      end
      ST_SEP: begin
        sel_word = word_cnt + 1'b1;
      end
      default: begin
      end
    endcase
    cur_word = shadow[int'(sel_word) * WBITS +: WBITS];
    digit    = nib2ascii(cur_word[int'(NIB_LAST - sel_nib) * 4 +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      word_cnt  <= '0;
      nib_cnt   <= '0;
      o_dout    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
`ifdef LSC_UART_HEX_CHKSUM_EN
      acc       <= '0;
`endif
    end else begin
      o_valid   <= 1'b0;
      o_overrun <= i_start & o_busy;

`ifdef LSC_UART_HEX_CHKSUM_EN
      // Digits and separators feed the checksum as they leave.
      if (state == ST_DIGIT || state == ST_SEP) begin
        acc <= acc ^ o_dout;
      end
`endif

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            shadow   <= i_data;
            word_cnt <= '0;
            nib_cnt  <= '0;
            o_busy   <= 1'b1;
            state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!WAIT_EMPTY || i_empty) begin
            o_dout  <= digit;
            o_valid <= 1'b1;
            state   <= ST_DIGIT;
`ifdef LSC_UART_HEX_CHKSUM_EN
            acc     <= '0;
`endif
          end
        end

        ST_DIGIT: begin
          o_valid <= 1'b1;
          if (nib_cnt != NIB_LAST) begin
            nib_cnt <= nib_cnt + 1'b1;
            o_dout  <= digit;
          end else if (word_cnt != WORD_LAST) begin
            o_dout <= SEP;
            state  <= ST_SEP;
          end else begin
`ifdef LSC_UART_HEX_CHKSUM_EN
            o_dout <= ASCII_STAR;
            state  <= ST_STAR;
`else
            o_dout <= ASCII_CR;
            state  <= ST_CR;
`endif
          end
        end

        ST_SEP: begin
          o_valid  <= 1'b1;
          word_cnt <= word_cnt + 1'b1;
          nib_cnt  <= '0;
          o_dout   <= digit;
          state    <= ST_DIGIT;
        end

`ifdef LSC_UART_HEX_CHKSUM_EN
        // acc is complete here: the last digit was folded in on leaving DIGIT.
        ST_STAR: begin
          o_valid <= 1'b1;
          o_dout  <= nib2ascii(acc[7:4]);
          state   <= ST_CK_HI;
        end

        ST_CK_HI: begin
          o_valid <= 1'b1;
          o_dout  <= nib2ascii(acc[3:0]);
          state   <= ST_CK_LO;
        end

        ST_CK_LO: begin
          o_valid <= 1'b1;
          o_dout  <= ASCII_CR;
          state   <= ST_CR;
        end
`endif

        ST_CR: begin
          o_valid <= 1'b1;
          o_dout  <= ASCII_LF;
          state   <= ST_LF;
        end

        ST_LF: begin
          o_dout <= '0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          o_dout <= '0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
